// File: rtl/reg_file_mp.sv
// Multi-port integer register file with x0 hardwired to zero, a pending-load scoreboard
// and a post-reset clear sweep. Optional write-first bypass: define REG_FILE_BYPASS_EN.
module reg_file_mp #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic [NRP*AW-1:0]     rd_addr,
    output logic [NRP*XLEN-1:0]   rd_data,
    output logic [NRP-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr
);

    localparam int            NREG = 2**AW;
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     clr_idx;
    logic [XLEN-1:0]   mem [NREG];
    logic [NREG-1:0]   busy;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_idx == LAST) begin
                    state_next = READY;
                end
            end
            READY: begin
                ready = 1'b1;
            end
            default: state_next = CLEAR;
        endcase
    end

    // NOTE: the array has no reset so it can map onto RAM/LUTRAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (reset_n) begin
            if (we0 && wa0 != '0) begin
                mem[wa0] <= wd0;
            end
            // Port 0 wins a same-address collision; the load data is dropped.
            if (we1 && wa1 != '0 && !(we0 && wa0 == wa1)) begin
                mem[wa1] <= wd1;
            end
        end
    end

    // Set is applied after clear so a newly issued load keeps the register pending.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (state == READY) begin
            if (we1) begin
                busy[wa1] <= 1'b0;
            end
            if (sb_set && sb_addr != '0) begin
                busy[sb_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            pend;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = mem[addr];
            pend = busy[addr];
`ifdef REG_FILE_BYPASS_EN
            if (we1 && wa1 == addr) begin
                data = wd1;
                if (!(sb_set && sb_addr == addr)) begin
                    pend = 1'b0;
                end
            end
            if (we0 && wa0 == addr) begin
                data = wd0;
            end
`endif
            if (state != READY || addr == '0) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data;
        assign rd_busy[p]              = pend;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: the driver pushes model predictions, a negedge monitor
// pops and compares them. Honours REG_FILE_BYPASS_EN the same way as the design.
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;
    localparam int NREG = 1 << AW;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                ready;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                we0, we1, sb_set;
    logic [AW-1:0]       wa0, wa1, sb_addr;
    logic [XLEN-1:0]     wd0, wd1;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ready   (ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .sb_set  (sb_set),
        .sb_addr (sb_addr)
    );

    typedef struct packed {
        logic                rst_n;
        logic [NRP*AW-1:0]   ra;
        logic                we0;
        logic [AW-1:0]       wa0;
        logic [XLEN-1:0]     wd0;
        logic                we1;
        logic [AW-1:0]       wa1;
        logic [XLEN-1:0]     wd1;
        logic                sb_set;
        logic [AW-1:0]       sb_addr;
    } stim_t;

    typedef struct {
        string               tag;
        logic                rdy;
        logic [NRP*XLEN-1:0] data;
        logic [NRP-1:0]      busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: register contents, pending flags and edges seen since reset release.
    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_busy [NREG];
    int              m_cnt = 0;
    bit              m_rdy = 1'b0;

    function automatic stim_t idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        for (int p = 0; p < NRP; p++) begin
            s.ra[p*AW +: AW] = (p == 0) ? a0 : a1;
        end
        return s;
    endfunction

    task automatic drive(input stim_t s, input string tag);
        exp_t          e;
        logic [AW-1:0] a;
        reset_n = s.rst_n;
        rd_addr = s.ra;
        we0     = s.we0;  wa0 = s.wa0;  wd0 = s.wd0;
        we1     = s.we1;  wa1 = s.wa1;  wd1 = s.wd1;
        sb_set  = s.sb_set;  sb_addr = s.sb_addr;

        e.tag  = tag;
        e.rdy  = m_rdy;
        e.data = '0;
        e.busy = '0;
        for (int p = 0; p < NRP; p++) begin
            a = s.ra[p*AW +: AW];
            if (m_rdy && a != '0) begin
                e.data[p*XLEN +: XLEN] = m_mem[a];
                e.busy[p]              = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
                if (s.we0 && s.wa0 == a)      e.data[p*XLEN +: XLEN] = s.wd0;
                else if (s.we1 && s.wa1 == a) e.data[p*XLEN +: XLEN] = s.wd1;
                if (s.we1 && s.wa1 == a && !(s.sb_set && s.sb_addr == a)) e.busy[p] = 1'b0;
`endif
            end
        end
        exp_q.push_back(e);

        @(posedge clk);
        if (!s.rst_n) begin
            m_rdy = 1'b0;
            m_cnt = 0;
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else if (!m_rdy) begin
            m_cnt++;
            if (m_cnt == NREG) begin
                m_rdy = 1'b1;
                for (int i = 0; i < NREG; i++) m_mem[i] = '0;
            end
        end else begin
            if (s.we1 && s.wa1 != '0) m_mem[s.wa1] = s.wd1;
            if (s.we0 && s.wa0 != '0) m_mem[s.wa0] = s.wd0;
            if (s.we1) m_busy[s.wa1] = 1'b0;
            if (s.sb_set && s.sb_addr != '0) m_busy[s.sb_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [NRP*XLEN-1:0] got, input logic [NRP*XLEN-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, " ready"}, (NRP*XLEN)'(ready),   (NRP*XLEN)'(e.rdy));
            check({e.tag, " rd_data"}, rd_data,            e.data);
            check({e.tag, " rd_busy"}, (NRP*XLEN)'(rd_busy), (NRP*XLEN)'(e.busy));
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        stim_t s;

        s = idle('0, '0);
        s.rst_n = 1'b0;
        reset_n = 1'b0;  rd_addr = '0;
        we0 = 1'b0;  wa0 = '0;  wd0 = '0;
        we1 = 1'b0;  wa1 = '0;  wd1 = '0;
        sb_set = 1'b0;  sb_addr = '0;
        @(posedge clk);
        #1;

        // Reset held, then a full sweep with writes and loads attempted throughout.
        for (int i = 0; i < 2; i++) drive(s, "reset");
        for (int i = 0; i < NREG; i++) begin
            s = idle(AW'(i), 5);
            s.we0 = 1'b1;  s.wa0 = AW'(i);  s.wd0 = $urandom;
            s.we1 = 1'b1;  s.wa1 = 5;       s.wd1 = $urandom;
            s.sb_set = 1'b1;  s.sb_addr = 9;
            drive(s, "sweep");
        end
        drive(idle(5, 9), "post_sweep");
        drive(idle(31, 1), "post_sweep");

        // Basic write and x0.
        s = idle(5, 0);  s.we0 = 1'b1;  s.wa0 = 5;  s.wd0 = 32'hDEADBEEF;  drive(s, "wr5");
        s = idle(0, 5);  s.we1 = 1'b1;  s.wa1 = 0;  s.wd1 = 32'h00001234;  drive(s, "wr0");
        drive(idle(5, 0), "rd5");
        drive(idle(0, 0), "rd0");

        // Write-port collision after a pending load on 7.
        s = idle(7, 7);  s.sb_set = 1'b1;  s.sb_addr = 7;  drive(s, "sb7");
        s = idle(7, 7);
        s.we0 = 1'b1;  s.wa0 = 7;  s.wd0 = 32'hAAAA0000;
        s.we1 = 1'b1;  s.wa1 = 7;  s.wd1 = 32'h5555FFFF;
        drive(s, "collide");
        drive(idle(7, 7), "rd7");

        // Scoreboard set / set-wins / clear / x0.
        s = idle(9, 9);  s.sb_set = 1'b1;  s.sb_addr = 9;  drive(s, "sb9");
        s = idle(9, 9);  s.sb_set = 1'b1;  s.sb_addr = 9;  s.we1 = 1'b1;  s.wa1 = 9;  s.wd1 = 32'h99;
        drive(s, "sb9_we1");
        s = idle(9, 9);  s.we1 = 1'b1;  s.wa1 = 9;  s.wd1 = 32'h9A;  drive(s, "we1_9");
        drive(idle(9, 9), "rd9");
        s = idle(0, 0);  s.sb_set = 1'b1;  s.sb_addr = 0;  drive(s, "sb0");
        drive(idle(0, 0), "rd0_busy");

        // Same-cycle read of a register being written.
        s = idle(12, 12);  s.we0 = 1'b1;  s.wa0 = 12;  s.wd0 = 32'h11111111;  drive(s, "wr12_old");
        s = idle(12, 12);  s.we0 = 1'b1;  s.wa0 = 12;  s.wd0 = 32'h0F0F0F0F;  drive(s, "bypass12");
        drive(idle(12, 12), "rd12");

        // Reset while READY with reg 3 = 0x77.
        s = idle(3, 3);  s.we0 = 1'b1;  s.wa0 = 3;  s.wd0 = 32'h77;  drive(s, "wr3");
        drive(idle(3, 3), "rd3");
        s = idle(3, 3);  s.rst_n = 1'b0;  drive(s, "rst_ready");
        for (int i = 0; i < NREG; i++) drive(idle(3, 5), "resweep");
        drive(idle(3, 5), "rd3_after");

        // Reset at sweep index 10.
        s = idle(3, 3);  s.rst_n = 1'b0;  drive(s, "rst_a");
        for (int i = 0; i < 10; i++) drive(idle(3, 5), "sweep_part");
        s = idle(3, 3);  s.rst_n = 1'b0;  drive(s, "rst_idx10");
        for (int i = 0; i < NREG; i++) drive(idle(3, 5), "sweep_restart");
        drive(idle(3, 9), "rd_after_restart");

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            s.rst_n = ($urandom_range(0, 299) != 0);
            for (int p = 0; p < NRP; p++) s.ra[p*AW +: AW] = rand_addr();
            s.we0 = 1'($urandom_range(0, 1));  s.wa0 = rand_addr();  s.wd0 = $urandom;
            s.we1 = 1'($urandom_range(0, 1));  s.wa1 = rand_addr();  s.wd1 = $urandom;
            s.sb_set = 1'($urandom_range(0, 1));  s.sb_addr = rand_addr();
            drive(s, "random");
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
